// File: rtl/tof_seq_pkg.sv
// Shared types and constants for the ToF I2C sequencer.
//   state_e      : sequencer FSM states
//   cfg_entry_t  : one init-table entry (register address + value)
//   *_REG        : sensor register addresses used by the polling loop
//   DRDY_*       : status-byte test for "range data ready"
package tof_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_POLL_WAIT,
    ST_STAT_ISSUE,
    ST_STAT_WAIT,
    ST_DIST_ISSUE,
    ST_DIST_WAIT,
    ST_CLR_ISSUE,
    ST_CLR_WAIT,
    ST_FAULT
  } state_e;

  localparam logic [15:0] STATUS_REG = 16'h0031;
  localparam logic [15:0] DIST_REG   = 16'h0096;
  localparam logic [15:0] CLR_REG    = 16'h0086;
  localparam logic [7:0]  DRDY_MASK  = 8'h01;
  localparam logic [7:0]  DRDY_VAL   = 8'h00;

  typedef struct packed {
    logic [15:0] reg_addr;
    logic [7:0]  value;
  } cfg_entry_t;

  // Every ISSUE state has exactly one matching WAIT state and vice versa.
  function automatic state_e issue_to_wait(input state_e s);
    case (s)
      ST_CFG_ISSUE:  return ST_CFG_WAIT;
      ST_STAT_ISSUE: return ST_STAT_WAIT;
      ST_DIST_ISSUE: return ST_DIST_WAIT;
      ST_CLR_ISSUE:  return ST_CLR_WAIT;
      default:       return ST_IDLE;
    endcase
  endfunction

  function automatic state_e wait_to_issue(input state_e s);
    case (s)
      ST_CFG_WAIT:  return ST_CFG_ISSUE;
      ST_STAT_WAIT: return ST_STAT_ISSUE;
      ST_DIST_WAIT: return ST_DIST_ISSUE;
      ST_CLR_WAIT:  return ST_CLR_ISSUE;
      default:      return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tof_cfg_rom.sv
// Init-table ROM for the ToF sensor.
//   idx   : entry index (0 .. CFG_DEPTH-1)
//   entry : register address / value pair for that index
// The final entry (CFG_DEPTH-1) is always the start-ranging write, so a
// shortened table still ends by starting the sensor.
module tof_cfg_rom
  import tof_seq_pkg::*;
#(
  parameter int CFG_DEPTH = 16
) (
  input  logic [5:0] idx,
  output cfg_entry_t entry
);

  always_comb begin
    entry = '{reg_addr: 16'h0000, value: 8'h00};
    if (idx == 6'(CFG_DEPTH - 1)) begin
      entry = '{reg_addr: 16'h0087, value: 8'h40};
    end else begin
      case (idx)
        6'd0:    entry = '{reg_addr: 16'h002D, value: 8'h00};
        6'd1:    entry = '{reg_addr: 16'h002E, value: 8'h01};
        6'd2:    entry = '{reg_addr: 16'h0030, value: 8'h01};
        6'd3:    entry = '{reg_addr: 16'h0046, value: 8'h20};
        6'd4:    entry = '{reg_addr: 16'h004B, value: 8'h03};
        6'd5:    entry = '{reg_addr: 16'h0060, value: 8'h0A};
        6'd6:    entry = '{reg_addr: 16'h0063, value: 8'h0E};
        6'd7:    entry = '{reg_addr: 16'h0069, value: 8'hB6};
        6'd8:    entry = '{reg_addr: 16'h0078, value: 8'h0A};
        6'd9:    entry = '{reg_addr: 16'h007B, value: 8'h00};
        6'd10:   entry = '{reg_addr: 16'h0080, value: 8'h01};
        6'd11:   entry = '{reg_addr: 16'h006C, value: 8'h00};
        6'd12:   entry = '{reg_addr: 16'h0050, value: 8'h00};
        6'd13:   entry = '{reg_addr: 16'h0051, value: 8'h38};
        6'd14:   entry = '{reg_addr: 16'h0086, value: 8'h01};
        default: entry = '{reg_addr: 16'h0000, value: 8'h00};
      endcase
    end
  end

endmodule

// File: rtl/tof_i2c_sequencer.sv
// Autonomous ToF sensor sequencer in front of I2C_Entity.
// Replays the init table, then loops: poll timer -> status read ->
// 2-byte distance read -> interrupt-clear write.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   enable                 : run the sequence; low returns to IDLE
//   i2c_ready/error        : I2C_Entity handshake (error valid when ready rises)
//   i2c_rd_data/rd_valid   : received read bytes
//   i2c_start .. wr_data   : registered transaction command to I2C_Entity
//   distance_mm/valid      : latest distance sample and its update strobe
//   init_done, busy, fault : sequencer status
module tof_i2c_sequencer
  import tof_seq_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h29,
  parameter int         CFG_DEPTH   = 16,
  parameter int         POLL_DIV    = 100000,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT_CYC = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        i2c_ready,
  input  logic        i2c_error,
  input  logic [7:0]  i2c_rd_data,
  input  logic        i2c_rd_valid,
  output logic        i2c_start,
  output logic        i2c_is_read,
  output logic [6:0]  i2c_slave_addr,
  output logic [15:0] i2c_reg_addr,
  output logic [9:0]  i2c_nb_bytes,
  output logic [7:0]  i2c_wr_data,
  output logic [15:0] distance_mm,
  output logic        distance_valid,
  output logic        init_done,
  output logic        busy,
  output logic        fault
);

  state_e      state_q, state_d;
  logic [5:0]  cfg_idx_q, cfg_idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] poll_q, poll_d;
  logic        seen_busy_q, seen_busy_d;
  logic        stop_q, stop_d;
  logic        byte_idx_q, byte_idx_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [15:0] dist_buf_q, dist_buf_d;
  logic [7:0]  status_q, status_d;
  logic        status_got_q, status_got_d;
  logic        start_q, start_d;
  logic        is_read_q, is_read_d;
  logic [15:0] reg_q, reg_d;
  logic [9:0]  nb_q, nb_d;
  logic [7:0]  wr_q, wr_d;
  logic [15:0] dist_q, dist_d;
  logic        dv_q, dv_d;
  logic        init_done_q, init_done_d;
  logic        fault_q, fault_d;

  cfg_entry_t  rom_entry;
  logic        is_wait;
  logic        done;
  logic        tmo_hit;
  logic        xfer_err;

  tof_cfg_rom #(.CFG_DEPTH(CFG_DEPTH)) u_rom (
    .idx   (cfg_idx_d),
    .entry (rom_entry)
  );

  always_comb begin
    state_d      = state_q;
    cfg_idx_d    = cfg_idx_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    poll_d       = poll_q;
    seen_busy_d  = seen_busy_q;
    stop_d       = stop_q;
    byte_idx_d   = byte_idx_q;
    rx_cnt_d     = rx_cnt_q;
    dist_buf_d   = dist_buf_q;
    status_d     = status_q;
    status_got_d = status_got_q;
    start_d      = 1'b0;
    dist_d       = dist_q;
    dv_d         = 1'b0;
    init_done_d  = init_done_q;
    fault_d      = fault_q;

    is_wait  = (state_q == ST_CFG_WAIT) || (state_q == ST_STAT_WAIT) ||
               (state_q == ST_DIST_WAIT) || (state_q == ST_CLR_WAIT);
    // Completion needs ready to have dropped first; a ready that never
    // drops only ever ends through the timeout.
    done     = i2c_ready && seen_busy_q;
    tmo_hit  = (tmo_q >= 32'(TIMEOUT_CYC - 1));
    xfer_err = 1'b0;

    if (is_wait) begin
      tmo_d = tmo_q + 32'd1;
      if (!i2c_ready) seen_busy_d = 1'b1;
      if (!enable)    stop_d      = 1'b1;
      if (i2c_rd_valid && state_q == ST_STAT_WAIT) begin
        status_d     = i2c_rd_data;
        status_got_d = 1'b1;
      end
      if (i2c_rd_valid && state_q == ST_DIST_WAIT) begin
        if (!byte_idx_q) dist_buf_d[15:8] = i2c_rd_data;
        else             dist_buf_d[7:0]  = i2c_rd_data;
        byte_idx_d = ~byte_idx_q;
        if (rx_cnt_q != 2'd3) rx_cnt_d = rx_cnt_q + 2'd1;
      end
      // A short distance read is handled like a bus error.
      xfer_err = i2c_error || ((state_q == ST_DIST_WAIT) && (rx_cnt_d != 2'd2));
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_CFG_ISSUE;
          cfg_idx_d = 6'd0;
          retry_d   = 8'd0;
        end
      end
      ST_CFG_ISSUE, ST_STAT_ISSUE, ST_DIST_ISSUE, ST_CLR_ISSUE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (i2c_ready) begin
          start_d      = 1'b1;
          state_d      = issue_to_wait(state_q);
          seen_busy_d  = 1'b0;
          stop_d       = 1'b0;
          tmo_d        = 32'd0;
          byte_idx_d   = 1'b0;
          rx_cnt_d     = 2'd0;
          status_got_d = 1'b0;
        end
      end
      ST_CFG_WAIT, ST_STAT_WAIT, ST_DIST_WAIT, ST_CLR_WAIT: begin
        if (done || tmo_hit) begin
          if (stop_q || !enable) begin
            // Disabled mid-transaction: let it finish, then park.
            state_d = ST_IDLE;
          end else if (done && !xfer_err) begin
            retry_d = 8'd0;
            case (state_q)
              ST_CFG_WAIT: begin
                if (cfg_idx_q == 6'(CFG_DEPTH - 1)) begin
                  init_done_d = 1'b1;
                  state_d     = ST_POLL_WAIT;
                  poll_d      = 32'(POLL_DIV - 1);
                end else begin
                  cfg_idx_d = cfg_idx_q + 6'd1;
                  state_d   = ST_CFG_ISSUE;
                end
              end
              ST_STAT_WAIT: begin
                if (status_got_d && ((status_d & DRDY_MASK) == DRDY_VAL)) begin
                  state_d = ST_DIST_ISSUE;
                end else begin
                  state_d = ST_POLL_WAIT;
                  poll_d  = 32'(POLL_DIV - 1);
                end
              end
              ST_DIST_WAIT: begin
                dist_d  = dist_buf_d;
                dv_d    = 1'b1;
                state_d = ST_CLR_ISSUE;
              end
              default: begin
                state_d = ST_POLL_WAIT;
                poll_d  = 32'(POLL_DIV - 1);
              end
            endcase
          end else if (retry_q == 8'(MAX_RETRY)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = wait_to_issue(state_q);
          end
        end
      end
      ST_POLL_WAIT: begin
        if (!enable)            state_d = ST_IDLE;
        else if (poll_q == 32'd0) state_d = ST_STAT_ISSUE;
        else                    poll_d  = poll_q - 32'd1;
      end
      ST_FAULT: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      init_done_d = 1'b0;
      fault_d     = 1'b0;
    end
  end

  // Command outputs are loaded whenever the next state is an ISSUE state
  // and then held untouched through the matching WAIT state.
  always_comb begin
    is_read_d = is_read_q;
    reg_d     = reg_q;
    nb_d      = nb_q;
    wr_d      = wr_q;
    case (state_d)
      ST_CFG_ISSUE: begin
        is_read_d = 1'b0;
        reg_d     = rom_entry.reg_addr;
        nb_d      = 10'd1;
        wr_d      = rom_entry.value;
      end
      ST_STAT_ISSUE: begin
        is_read_d = 1'b1;
        reg_d     = STATUS_REG;
        nb_d      = 10'd1;
        wr_d      = 8'h00;
      end
      ST_DIST_ISSUE: begin
        is_read_d = 1'b1;
        reg_d     = DIST_REG;
        nb_d      = 10'd2;
        wr_d      = 8'h00;
      end
      ST_CLR_ISSUE: begin
        is_read_d = 1'b0;
        reg_d     = CLR_REG;
        nb_d      = 10'd1;
        wr_d      = 8'h01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cfg_idx_q    <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      poll_q       <= '0;
      seen_busy_q  <= 1'b0;
      stop_q       <= 1'b0;
      byte_idx_q   <= 1'b0;
      rx_cnt_q     <= '0;
      dist_buf_q   <= '0;
      status_q     <= '0;
      status_got_q <= 1'b0;
      start_q      <= 1'b0;
      is_read_q    <= 1'b0;
      reg_q        <= '0;
      nb_q         <= '0;
      wr_q         <= '0;
      dist_q       <= '0;
      dv_q         <= 1'b0;
      init_done_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_idx_q    <= cfg_idx_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      poll_q       <= poll_d;
      seen_busy_q  <= seen_busy_d;
      stop_q       <= stop_d;
      byte_idx_q   <= byte_idx_d;
      rx_cnt_q     <= rx_cnt_d;
      dist_buf_q   <= dist_buf_d;
      status_q     <= status_d;
      status_got_q <= status_got_d;
      start_q      <= start_d;
      is_read_q    <= is_read_d;
      reg_q        <= reg_d;
      nb_q         <= nb_d;
      wr_q         <= wr_d;
      dist_q       <= dist_d;
      dv_q         <= dv_d;
      init_done_q  <= init_done_d;
      fault_q      <= fault_d;
    end
  end

  assign i2c_start      = start_q;
  assign i2c_is_read    = is_read_q;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_reg_addr   = reg_q;
  assign i2c_nb_bytes   = nb_q;
  assign i2c_wr_data    = wr_q;
  assign distance_mm    = dist_q;
  assign distance_valid = dv_q;
  assign init_done      = init_done_q;
  assign fault          = fault_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_FAULT);

endmodule

// File: doc/tof_i2c_sequencer.md
Name: tof_i2c_sequencer

Overview:
Autonomous command sequencer that drives I2C_Entity to configure the ToF sensor (default address 7'h29, 16-bit register map) and then polls it for range results. It replays a fixed init table of register writes, then loops: poll timer → status read → 2-byte distance read → interrupt-clear write. It sits between I2C_Entity and the fabric logic that consumes distance samples. It owns I2C_Entity exclusively; no other master drives its command inputs.

Parameters:
SLAVE_ADDR, 7'h29, 7-bit sensor address driven on every transaction
CFG_DEPTH, 16, number of init-table entries (1..64)
POLL_DIV, 100000, clock cycles between status polls (>=2)
MAX_RETRY, 3, retries per transaction after error/timeout before FAULT
TIMEOUT_CYC, 2000000, max cycles a transaction may take before it counts as an error

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run sequence; low returns to IDLE once any in-flight transaction completes
i2c_ready  in  1  I2C_Entity ready (high = idle and able to accept start)
i2c_error  in  1  I2C_Entity error_out, sampled when ready returns high
i2c_rd_data  in  8  read byte from I2C_Entity
i2c_rd_valid  in  1  one-cycle strobe per received read byte
i2c_start  out  1  one-cycle transaction start to I2C_Entity
i2c_is_read  out  1  1 = read, 0 = write
i2c_slave_addr  out  7  = SLAVE_ADDR
i2c_reg_addr  out  16  register address of current transaction
i2c_nb_bytes  out  10  byte count of current transaction
i2c_wr_data  out  8  write byte (data_in of I2C_Entity)
distance_mm  out  16  last distance result, MSB = first byte received
distance_valid  out  1  one-cycle pulse when distance_mm updates
init_done  out  1  high after the whole init table was written; cleared on IDLE
busy  out  1  high in any state except IDLE and FAULT
fault  out  1  sticky; set on retry exhaustion, cleared by reset or enable low

Behaviour:
- Reset: all outputs 0 except i2c_slave_addr = SLAVE_ADDR. State IDLE. Counters 0.
- States: IDLE, CFG_ISSUE, CFG_WAIT, POLL_WAIT, STAT_ISSUE, STAT_WAIT, DIST_ISSUE, DIST_WAIT, CLR_ISSUE, CLR_WAIT, FAULT.
- IDLE → CFG_ISSUE when enable=1. cfg_idx=0.
- *_ISSUE: command outputs are registered and stable from the ISSUE state until WAIT exits. i2c_start=1 for exactly one cycle, in the first ISSUE cycle with i2c_ready=1. The next state is the matching WAIT.
- *_WAIT: set a seen_busy flag on the first cycle i2c_ready=0. Completion is i2c_ready=1 with seen_busy=1. A ready that never drops is not completion.
- On completion with i2c_error=0: advance. On completion with i2c_error=1, or when the timeout counter reaches TIMEOUT_CYC: retry_cnt++ and return to the same ISSUE state. If retry_cnt was already MAX_RETRY, go to FAULT instead. retry_cnt clears on every successful transaction.
- CFG: entry cfg_idx gives write, nb_bytes=1, reg/value from the table. After success, cfg_idx++. After entry CFG_DEPTH-1: init_done=1 and go to POLL_WAIT.
- POLL_WAIT: the poll counter counts POLL_DIV-1 down to 0, then goes to STAT_ISSUE.
- STAT: read, reg STATUS_REG, 1 byte, captured on i2c_rd_valid.
  - Data ready when (status & DRDY_MASK) == DRDY_VAL → DIST_ISSUE.
  - Otherwise → POLL_WAIT.
  - If no byte was received, treat the status as not ready.
- DIST: read, reg DIST_REG, 2 bytes. Byte 0 → distance[15:8], byte 1 → distance[7:0]; byte counter wraps at 2.
  - distance_mm and distance_valid update in the cycle after completion, only if exactly 2 bytes arrived.
  - If fewer arrived, treat it as an error (retry path).
- CLR: write 8'h01 to CLR_REG, 1 byte, then → POLL_WAIT.
- enable=0 in an ISSUE state or POLL_WAIT: go to IDLE next cycle.
- enable=0 in a WAIT state: finish the transaction, then go to IDLE with no retry. init_done=0.
- FAULT: outputs idle, i2c_start=0. Leave only by reset, or by enable=0 → IDLE (fault clears).
- Reset mid-transaction: the sequencer returns to IDLE immediately. I2C_Entity is reset by the same reset.
- i2c_rd_valid outside STAT_WAIT or DIST_WAIT is ignored.

Decomposition:
- Package tof_seq_pkg:
  - state enum.
  - STATUS_REG 16'h0031, DIST_REG 16'h0096, CLR_REG 16'h0086, DRDY_MASK 8'h01, DRDY_VAL 8'h00.
  - cfg_entry_t struct {reg_addr[15:0], value[7:0]}.
- Sub-module tof_cfg_rom: combinational index → cfg_entry_t, CFG_DEPTH entries. The last entry is the start-ranging write (16'h0087 ← 8'h40).

Test Plan:
1. CFG_DEPTH=4, I2C model acks all → exactly 4 write starts with the ROM reg/value pairs in order, nb_bytes=1, is_read=0; then init_done=1.
2. POLL_DIV=8, status returns 8'h01 twice then 8'h00 → one start every 8+txn cycles; DIST read issued only after the third status read.
3. DIST returns 8'h01, 8'hF4 → distance_mm=16'h01F4 with a single-cycle distance_valid, followed by a CLR write of 8'h01 to 16'h0086.
4. MAX_RETRY=3, model asserts error on CFG entry 2 three times then succeeds → 4 starts on entry 2 and the sequence continues. Erroring 4 times → fault=1, busy=0, no further starts.
5. Model holds i2c_ready low beyond TIMEOUT_CYC=50 → counted as an error and a retry is issued. A ready that never drops produces no false completion.
6. enable dropped mid DIST_WAIT → the transaction completes, distance is not updated, IDLE follows and init_done=0. Re-enable replays the table from entry 0.
